// File: rtl/pixel_frame_sequencer.sv
// Frame controller for the pixel sensor: erase, expose, ramp conversion, row latch and beat streaming.
// Optional macro SENSOR_TEST_PATTERN_EN adds a test_pattern input that substitutes a synthetic row.
module pixel_frame_sequencer #(
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLS         = 4,
    parameter int unsigned PIXEL_BITS   = 8,
    parameter int unsigned BUS_WIDTH    = 2,
    parameter int unsigned ERASE_CYCLES = 2,
    parameter int unsigned EXP_W        = 16
) (
    input  logic                            clk,
    input  logic                            reset,
`ifdef SENSOR_TEST_PATTERN_EN
    input  logic                            test_pattern,
`endif
    input  logic                            start,
    input  logic                            continuous,
    input  logic [EXP_W-1:0]                expose_cycles,
    output logic                            busy,
    output logic                            p_erase,
    output logic                            p_expose,
    output logic                            p_aramp,
    output logic [PIXEL_BITS-1:0]           p_dramp,
    output logic [ROWS-1:0]                 p_row_select,
    input  logic [COLS*PIXEL_BITS-1:0]      row_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BUS_WIDTH*PIXEL_BITS-1:0] out_data,
    output logic                            out_last,
    output logic                            out_sof,
    output logic                            frame_done,
    output logic [15:0]                     frame_count
);

    localparam int unsigned ROW_W   = COLS * PIXEL_BITS;
    localparam int unsigned BEAT_W  = BUS_WIDTH * PIXEL_BITS;
    localparam int unsigned BEATS   = COLS / BUS_WIDTH;
    localparam int unsigned BEAT_IW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned ROW_IW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ERASE_W = $clog2(ERASE_CYCLES + 1);
    localparam int unsigned CNT_W   = ((EXP_W > ERASE_W) ? EXP_W : ERASE_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_LATCH,
        S_STREAM
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [EXP_W-1:0]    exp_q;
    logic [ROW_IW-1:0]   row_idx;
    logic [BEAT_IW-1:0]  beat_idx;
    logic [ROW_W-1:0]    row_buf;

    logic [ROW_W-1:0]    capture_row_c;
    logic [EXP_W-1:0]    exp_latch_c;
    logic [BEAT_IW-1:0]  next_beat_c;
    logic [ROW_IW-1:0]   next_row_c;

    // A zero exposure request still exposes for one cycle.
    assign exp_latch_c = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;
    assign next_beat_c = beat_idx + BEAT_IW'(1);
    assign next_row_c  = row_idx + ROW_IW'(1);

`ifdef SENSOR_TEST_PATTERN_EN
    // Synthetic row: pixel c of row r is (r + c) modulo the pixel range.
    always_comb begin
        capture_row_c = row_data;
        if (test_pattern) begin
            for (int c = 0; c < COLS; c++) begin
                capture_row_c[c*PIXEL_BITS +: PIXEL_BITS] = PIXEL_BITS'(row_idx) + PIXEL_BITS'(c);
            end
        end
    end
`else
    assign capture_row_c = row_data;
`endif

    // Sequencer; every output is set for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            exp_q        <= '0;
            row_idx      <= '0;
            beat_idx     <= '0;
            row_buf      <= '0;
            busy         <= 1'b0;
            p_erase      <= 1'b0;
            p_expose     <= 1'b0;
            p_aramp      <= 1'b0;
            p_dramp      <= '0;
            p_row_select <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            out_sof      <= 1'b0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_ERASE;
                        exp_q   <= exp_latch_c;
                        cnt     <= '0;
                        row_idx <= '0;
                        busy    <= 1'b1;
                        p_erase <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (cnt == CNT_W'(ERASE_CYCLES - 1)) begin
                        state    <= S_EXPOSE;
                        cnt      <= '0;
                        p_erase  <= 1'b0;
                        p_expose <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_EXPOSE: begin
                    if (cnt + CNT_W'(1) == CNT_W'(exp_q)) begin
                        state    <= S_CONVERT;
                        cnt      <= '0;
                        p_expose <= 1'b0;
                        p_aramp  <= 1'b1;
                        p_dramp  <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_CONVERT: begin
                    if (p_dramp == {PIXEL_BITS{1'b1}}) begin
                        state        <= S_LATCH;
                        p_aramp      <= 1'b0;
                        p_dramp      <= '0;
                        p_row_select <= ROWS'(1) << row_idx;
                    end else begin
                        p_dramp <= p_dramp + PIXEL_BITS'(1);
                    end
                end
                S_LATCH: begin
                    state        <= S_STREAM;
                    p_row_select <= '0;
                    row_buf      <= capture_row_c;
                    beat_idx     <= '0;
                    out_valid    <= 1'b1;
                    out_data     <= capture_row_c[BEAT_W-1:0];
                    out_last     <= (BEATS == 1);
                    out_sof      <= (row_idx == '0);
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (beat_idx == BEAT_IW'(BEATS - 1)) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_sof   <= 1'b0;
                            if (row_idx == ROW_IW'(ROWS - 1)) begin
                                frame_done  <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                                row_idx     <= '0;
                                if (continuous) begin
                                    state   <= S_ERASE;
                                    exp_q   <= exp_latch_c;
                                    cnt     <= '0;
                                    p_erase <= 1'b1;
                                end else begin
                                    state <= S_IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                state        <= S_LATCH;
                                row_idx      <= next_row_c;
                                p_row_select <= ROWS'(1) << next_row_c;
                            end
                        end else begin
                            beat_idx <= next_beat_c;
                            out_data <= row_buf[next_beat_c*BEAT_W +: BEAT_W];
                            out_last <= (next_beat_c == BEAT_IW'(BEATS - 1));
                            out_sof  <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer: table of single-shot frames plus continuous and reset sequences.
module tb_pixel_frame_sequencer;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned PB    = 8;
    localparam int unsigned BUS   = 2;
    localparam int unsigned ERASE = 2;
    localparam int unsigned EXP_W = 16;
    localparam int unsigned BEATS = COLS / BUS;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                continuous = 1'b0;
    logic [EXP_W-1:0]    expose_cycles = '0;
    logic                busy, p_erase, p_expose, p_aramp;
    logic [PB-1:0]       p_dramp;
    logic [ROWS-1:0]     p_row_select;
    logic [COLS*PB-1:0]  row_data;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [BUS*PB-1:0]   out_data;
    logic                out_last, out_sof, frame_done;
    logic [15:0]         frame_count;
`ifdef SENSOR_TEST_PATTERN_EN
    logic                test_pattern = 1'b0;
`endif

    typedef struct packed {
        logic [BUS*PB-1:0] data;
        logic              last;
        logic              sof;
    } beat_t;

    typedef struct {
        logic [EXP_W-1:0] expose;
        bit               rnd;
        bit               poke;
        bit               pat;
        logic [7:0]       seed;
        int               exp_len;
        int               lat;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          fc = 0;
    int          done_cnt = 0;
    bit          rdy_mode = 1'b0;
    logic [7:0]  seed = 8'h00;
    beat_t       got[$];
    vec_t        vecs[$];
    bit          prev_stall = 1'b0;
    logic [BUS*PB-1:0] prev_data = '0;

    pixel_frame_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .PIXEL_BITS(PB),
        .BUS_WIDTH(BUS), .ERASE_CYCLES(ERASE), .EXP_W(EXP_W)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef SENSOR_TEST_PATTERN_EN
        .test_pattern(test_pattern),
`endif
        .start(start),
        .continuous(continuous),
        .expose_cycles(expose_cycles),
        .busy(busy),
        .p_erase(p_erase),
        .p_expose(p_expose),
        .p_aramp(p_aramp),
        .p_dramp(p_dramp),
        .p_row_select(p_row_select),
        .row_data(row_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .out_sof(out_sof),
        .frame_done(frame_done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [7:0] exp_pix(input int r, input int c, input bit pat, input logic [7:0] sd);
        if (pat) return 8'(r + c);
        return 8'(int'(sd) + r * 16 + c);
    endfunction

    // Pixel array model: the selected row presents seed + row*16 + column.
    always_comb begin
        row_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (p_row_select[r]) begin
                for (int c = 0; c < COLS; c++) begin
                    row_data[c*PB +: PB] = exp_pix(r, c, 1'b0, seed);
                end
            end
        end
    end

    // Consumer readiness changes just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Beat collector and stall-hold checker.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) got.push_back('{out_data, out_last, out_sof});
            if (frame_done) done_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic compare_sb(input int nframes, input bit pat, input logic [7:0] sd);
        int k;
        int r;
        logic [BUS*PB-1:0] e;
        check("beat_count", 64'(got.size()), 64'(nframes * ROWS * BEATS));
        for (int i = 0; i < got.size() && i < nframes * ROWS * BEATS; i++) begin
            k = i % BEATS;
            r = (i / BEATS) % ROWS;
            for (int j = 0; j < BUS; j++) e[j*PB +: PB] = exp_pix(r, k * BUS + j, pat, sd);
            check("beat_data", 64'(got[i].data), 64'(e));
            check("beat_last", 64'(got[i].last), 64'(k == BEATS - 1));
            check("beat_sof", 64'(got[i].sof), 64'(r == 0 && k == 0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_erase"}, 64'(p_erase), 64'd0);
        check({tag, "_expose"}, 64'(p_expose), 64'd0);
        check({tag, "_aramp"}, 64'(p_aramp), 64'd0);
        check({tag, "_dramp"}, 64'(p_dramp), 64'd0);
        check({tag, "_rowsel"}, 64'(p_row_select), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_last"}, 64'(out_last), 64'd0);
        check({tag, "_sof"}, 64'(out_sof), 64'd0);
        check({tag, "_done"}, 64'(frame_done), 64'd0);
        check({tag, "_count"}, 64'(frame_count), 64'd0);
    endtask

    task automatic run_frame(input vec_t v);
        int k = 0;
        int n_erase = 0;
        int n_exp = 0;
        int n_ramp = 0;
        int guard = 0;
        bit poked = 1'b0;
        got.delete();
        done_cnt = 0;
        seed = v.seed;
        rdy_mode = v.rnd;
`ifdef SENSOR_TEST_PATTERN_EN
        test_pattern = v.pat;
`endif
        continuous = 1'b0;
        expose_cycles = v.expose;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_erase", 64'(p_erase), 64'd1);
        while (!out_valid && k < 3000) begin
            n_erase += int'(p_erase);
            n_exp   += int'(p_expose);
            n_ramp  += int'(p_aramp);
            if (v.poke && p_expose && !poked) begin
                start = 1'b1;
                expose_cycles = 16'd50;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            k++;
        end
        start = 1'b0;
        check("first_beat_latency", 64'(k), 64'(v.lat));
        check("erase_len", 64'(n_erase), 64'(ERASE));
        check("expose_len", 64'(n_exp), 64'(v.exp_len));
        check("ramp_len", 64'(n_ramp), 64'd256);
        check("first_sof", 64'(out_sof), 64'd1);
        while (!frame_done && guard < 2000) begin
            step();
            guard++;
        end
        check("frame_done_seen", 64'(frame_done), 64'd1);
        fc++;
        check("frame_count", 64'(frame_count), 64'(16'(fc)));
        check("busy_at_done", 64'(busy), 64'd0);
        repeat (5) step();
        check("idle_busy", 64'(busy), 64'd0);
        check("done_pulses", 64'(done_cnt), 64'd1);
        compare_sb(1, v.pat, v.seed);
    endtask

    initial begin
        int guard;
        vec_t fresh;
        //                expose  rnd   poke  pat   seed   exp_len lat
        vecs.push_back('{16'd5,  1'b0, 1'b0, 1'b0, 8'h00, 5,      264});
        vecs.push_back('{16'd0,  1'b1, 1'b0, 1'b0, 8'h40, 1,      260});
        vecs.push_back('{16'd10, 1'b0, 1'b1, 1'b0, 8'h05, 10,     269});
        vecs.push_back('{16'd1,  1'b1, 1'b0, 1'b0, 8'h80, 1,      260});
`ifdef SENSOR_TEST_PATTERN_EN
        vecs.push_back('{16'd2,  1'b0, 1'b0, 1'b1, 8'h30, 2,      261});
`endif
        fresh = '{16'd3, 1'b0, 1'b0, 1'b0, 8'h11, 3, 262};

        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        foreach (vecs[i]) run_frame(vecs[i]);
`ifdef SENSOR_TEST_PATTERN_EN
        test_pattern = 1'b0;
`endif

        // Continuous frames, dropping continuous during the fourth frame.
        got.delete();
        done_cnt = 0;
        seed = 8'h20;
        rdy_mode = 1'b1;
        expose_cycles = 16'd3;
        continuous = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int f = 0; f < 4; f++) begin
            guard = 0;
            while (!frame_done && guard < 3000) begin
                if (f == 3 && out_valid) continuous = 1'b0;
                step();
                guard++;
            end
            check("cont_done_seen", 64'(frame_done), 64'd1);
            fc++;
            check("cont_count", 64'(frame_count), 64'(16'(fc)));
            check("cont_busy", 64'(busy), 64'(f < 3));
            check("cont_erase", 64'(p_erase), 64'(f < 3));
            step();
        end
        repeat (10) step();
        check("cont_idle", 64'(busy), 64'd0);
        check("cont_pulses", 64'(done_cnt), 64'd4);
        compare_sb(4, 1'b0, 8'h20);

        // Reset while streaming row 2, beat 1.
        got.delete();
        seed = 8'h10;
        rdy_mode = 1'b0;
        expose_cycles = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (!(out_valid && got.size() == 5) && guard < 3000) begin
            step();
            guard++;
        end
        check("reset_point_reached", 64'(out_valid && got.size() == 5), 64'd1);
        reset = 1'b1;
        step();
        check_all_zero("midreset");
        reset = 1'b0;
        fc = 0;
        step();
        run_frame(fresh);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_frame_sequencer.md
# pixel_frame_sequencer

Parametrised single-clock frame controller for the pixel sensor. It sequences erase, expose, ramp-ADC conversion and row readout for a ROWS×COLS pixel array. It buffers each converted row and streams it out BUS_WIDTH pixels per beat over a valid/ready interface with backpressure. It adds a programmable exposure time, continuous/single-shot modes and a frame counter, and sits between the pixel array and the downstream pixel consumer.

## Interface
Parameters:
- ROWS, 4, pixel array height (≥1)
- COLS, 4, pixel array width; must be a multiple of BUS_WIDTH
- PIXEL_BITS, 8, bits per pixel and digital ramp width
- BUS_WIDTH, 2, pixels per output beat
- ERASE_CYCLES, 2, erase pulse length (≥1)
- EXP_W, 16, width of exposure-time input

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  begin a frame; sampled in IDLE only
- continuous  in  1  1 = loop frames, 0 = single-shot
- expose_cycles  in  EXP_W  exposure length in clk cycles, latched on start
- busy  out  1  high in every state except IDLE
- p_erase  out  1  array erase
- p_expose  out  1  array expose
- p_aramp  out  1  analog ramp enable
- p_dramp  out  PIXEL_BITS  digital ramp counter to array
- p_row_select  out  ROWS  one-hot row read select
- row_data  in  COLS×PIXEL_BITS  selected row from array; pixel c at bits [c·PIXEL_BITS +: PIXEL_BITS]
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_data  out  BUS_WIDTH×PIXEL_BITS  beat; lowest-index pixel in LSBs
- out_last  out  1  final beat of a row
- out_sof  out  1  first beat of a frame
- frame_done  out  1  one-cycle pulse at end of frame
- frame_count  out  16  completed frames, wraps 0xFFFF→0

## Operation
- States: IDLE → ERASE → EXPOSE → CONVERT → LATCH → STREAM → (LATCH next row | frame end).
- IDLE: all control outputs 0. On start=1, latch expose_cycles (0 treated as 1) and go to ERASE.
- ERASE: p_erase=1 for ERASE_CYCLES cycles.
- EXPOSE: p_expose=1 for the latched exposure count.
- CONVERT: p_aramp=1; p_dramp counts 0…2^PIXEL_BITS−1, one step per cycle. This state lasts 2^PIXEL_BITS cycles.
- LATCH (row r, r=0 first): p_row_select = one-hot bit r for exactly 1 cycle. The row buffer captures row_data at the end of that cycle.
- STREAM: out_valid=1; beat k carries pixels k·BUS_WIDTH … k·BUS_WIDTH+BUS_WIDTH−1. The beat index advances only on out_valid&out_ready. out_data is held stable while out_valid=1 and out_ready=0.
- out_last=1 on beat COLS/BUS_WIDTH−1. out_sof=1 on beat 0 of row 0.
- After the last beat of row r<ROWS−1 is accepted, go to LATCH for r+1.
- After the last beat of row ROWS−1 is accepted, frame end:
  - frame_done pulses and frame_count increments, both in the next cycle.
  - continuous is sampled at the accepting handshake: if 1, go to ERASE and re-latch expose_cycles; if 0, go to IDLE.
- start is ignored while busy=1. Changing expose_cycles mid-frame has no effect until the next latch point.

## Timing
- Reset: next edge returns state to IDLE and clears every output to 0 (busy, p_*, out_*, frame_done, frame_count). Row and beat counters also clear to 0. This applies from any state, including mid-stream; a partially streamed row is discarded.
- start at edge N: busy=1 and p_erase=1 from cycle N+1.
- Start-to-first-beat latency with out_ready=1: ERASE_CYCLES + max(exp,1) + 2^PIXEL_BITS + 1 cycles, counted from the cycle after start.
- With out_ready held 1, a row streams in COLS/BUS_WIDTH consecutive cycles, followed by 1 LATCH cycle per subsequent row.
- Row-to-row gap is exactly one LATCH cycle; out_valid=0 during it.
- frame_done and busy: in single-shot mode, busy falls in the same cycle frame_done is high. In continuous mode busy stays 1 and p_erase=1 in the same cycle as frame_done.

## Configuration
- SENSOR_TEST_PATTERN_EN: when defined, adds input port test_pattern (1 bit).
  - If test_pattern=1 during LATCH, the buffer loads a synthetic row instead of row_data: pixel c of row r = (r + c) mod 2^PIXEL_BITS.
  - All timing is unchanged.
- When undefined, the port and the pattern logic are absent and row_data is always captured.

## Test plan
- Single-shot, defaults, expose=5, out_ready=1, row_data = row index ×16 + column:
  - first beat appears 2+5+256+1 cycles after start, with out_sof=1 and out_data = {0x01,0x00}.
  - 8 beats total; out_last on beats 1,3,5,7.
  - frame_done pulses once; frame_count=1; busy=0 after.
- Backpressure: toggle out_ready randomly → out_data and out_valid hold while stalled, and no beat is lost or duplicated (compare against a scoreboard).
- Continuous=1 for 3 frames, then dropped mid-frame 4 → exactly 4 frame_done pulses; frame_count=4; returns to IDLE.
- Reset asserted during STREAM row 2, beat 1 → next cycle all outputs 0; a fresh start produces a full, correct frame beginning with out_sof.
- expose_cycles=0 → p_expose high exactly 1 cycle. A start pulse during EXPOSE is ignored.
- With SENSOR_TEST_PATTERN_EN and test_pattern=1, ROWS=4, COLS=4 → row 3 beats are {0x04,0x03} and {0x06,0x05}.
